// File: rtl/oled_ctrl_if.sv
// oled_if: signal bundle between the controller and the Pmod OLEDrgb panel.
//   cs      - SPI chip select, active low
//   mosi    - SPI data, MSB first
//   dc_c    - data/command qualifier (0 = command, 1 = data)
//   res     - panel reset, active low
//   vss_en  - panel high-voltage rail enable
//   pmod_en - logic supply enable
// The master modport is the controller side; slave is the panel side.
interface oled_if;
  logic cs;
  logic mosi;
  logic dc_c;
  logic res;
  logic vss_en;
  logic pmod_en;

  modport master (output cs, output mosi, output dc_c, output res, output vss_en, output pmod_en);
  modport slave  (input  cs, input  mosi, input  dc_c, input  res, input  vss_en, input  pmod_en);
endinterface

// File: rtl/oled_ctrl.sv
// oled_ctrl: power sequencer and SPI (mode 3) byte transmitter for the
// Pmod OLEDrgb display.
//   clk, rst           - clock, asynchronous active-high reset
//   oled               - panel rails, reset line and SPI cs/mosi/dc_c
//   sclk               - SPI clock, idles high
//   power_on, vcc_on   - level requests for logic supply and HV rail
//   tx_valid/tx_ready  - byte handshake; tx_data (MSB first), tx_dc
//   init_ready         - panel powered and accepting bytes (INIT/VCC_WAIT/RUN)
//   display_on         - HV rail settled (RUN)
// Every panel-facing output is a register; the power outputs are loaded from
// the next-state decode so they line up exactly with the state register.
module oled_ctrl #(
  parameter int CLK_DIV = 8,
  parameter int T_VDD   = 2_000_000,
  parameter int T_RES   = 300,
  parameter int T_VCC   = 10_000_000,
  parameter int T_OFF   = 40_000_000
) (
  input  logic       clk,
  input  logic       rst,
  oled_if.master     oled,
  output logic       sclk,
  input  logic       power_on,
  input  logic       vcc_on,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_dc,
  output logic       init_ready,
  output logic       display_on
);

  typedef enum logic [2:0] {
    S_OFF, S_VDD_WAIT, S_RES_LOW, S_RES_WAIT, S_INIT, S_VCC_WAIT, S_RUN, S_OFF_WAIT
  } state_t;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [31:0] VDD_LAST = 32'(T_VDD - 1);
  localparam logic [31:0] RES_LAST = 32'(T_RES - 1);
  localparam logic [31:0] VCC_LAST = 32'(T_VCC - 1);
  localparam logic [31:0] OFF_LAST = 32'(T_OFF - 1);

  state_t      state_reg, state_next;
  logic [31:0] cnt_reg, cnt_next;

  // Shifter: half_reg counts SCLK half-periods since cs fell (0..17),
  // div_reg counts clk cycles inside one half-period.
  logic             busy_reg;
  logic [DIV_W-1:0] div_reg;
  logic [4:0]       half_reg;
  logic [4:0]       half_inc;
  logic [6:0]       shift_reg;
  logic             cs_reg, mosi_reg, dc_reg, sclk_reg;

  logic res_reg, vss_reg, pmod_reg, init_reg, disp_reg;
  logic xfer_state;
  logic accept;

  assign half_inc = half_reg + 5'd1;

  // Next state, shared delay counter and transfer acceptance.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_OFF:      if (power_on) state_next = S_VDD_WAIT;
      S_VDD_WAIT: begin
        if (!power_on)               state_next = S_OFF;
        else if (cnt_reg == VDD_LAST) state_next = S_RES_LOW;
      end
      S_RES_LOW:  begin
        if (!power_on)               state_next = S_OFF;
        else if (cnt_reg == RES_LAST) state_next = S_RES_WAIT;
      end
      S_RES_WAIT: begin
        if (!power_on)               state_next = S_OFF;
        else if (cnt_reg == RES_LAST) state_next = S_INIT;
      end
      S_INIT: begin
        // Exits wait for the shifter; power-down wins over vcc_on.
        if (!busy_reg) begin
          if (!power_on)   state_next = S_OFF;
          else if (vcc_on) state_next = S_VCC_WAIT;
        end
      end
      S_VCC_WAIT: if (cnt_reg == VCC_LAST) state_next = S_RUN;
      S_RUN:      if (!busy_reg && (!vcc_on || !power_on)) state_next = S_OFF_WAIT;
      S_OFF_WAIT: if (cnt_reg == OFF_LAST) state_next = power_on ? S_INIT : S_OFF;
    endcase

    cnt_next = cnt_reg;
    if (state_next != state_reg) begin
      cnt_next = '0;
    end else if (state_reg == S_VDD_WAIT || state_reg == S_RES_LOW ||
                 state_reg == S_RES_WAIT || state_reg == S_VCC_WAIT ||
                 state_reg == S_OFF_WAIT) begin
      cnt_next = cnt_reg + 32'd1;
    end

    xfer_state = (state_reg == S_INIT) || (state_reg == S_VCC_WAIT) || (state_reg == S_RUN);
    // A byte is never taken in the same cycle the state is about to change.
    tx_ready   = xfer_state && !busy_reg && (state_next == state_reg);
    accept     = tx_valid && tx_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_OFF;
      cnt_reg   <= '0;
      pmod_reg  <= 1'b0;
      res_reg   <= 1'b1;
      vss_reg   <= 1'b0;
      init_reg  <= 1'b0;
      disp_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pmod_reg  <= (state_next != S_OFF);
      res_reg   <= (state_next != S_RES_LOW);
      vss_reg   <= (state_next == S_VCC_WAIT) || (state_next == S_RUN);
      init_reg  <= (state_next == S_INIT) || (state_next == S_VCC_WAIT) ||
                   (state_next == S_RUN);
      disp_reg  <= (state_next == S_RUN);
    end
  end

  // Frame timeline in half-periods after cs falls:
  //   odd 1..15  -> SCLK falls (mosi advances from the 2nd fall on)
  //   even 2..16 -> SCLK rises (panel samples)
  //   17         -> cs released
  //   18         -> shifter idle again
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg  <= 1'b0;
      div_reg   <= '0;
      half_reg  <= '0;
      shift_reg <= '0;
      cs_reg    <= 1'b1;
      mosi_reg  <= 1'b0;
      dc_reg    <= 1'b0;
      sclk_reg  <= 1'b1;
    end else if (accept) begin
      busy_reg  <= 1'b1;
      div_reg   <= '0;
      half_reg  <= '0;
      shift_reg <= tx_data[6:0];
      cs_reg    <= 1'b0;
      mosi_reg  <= tx_data[7];
      dc_reg    <= tx_dc;
      sclk_reg  <= 1'b1;
    end else if (busy_reg) begin
      if (div_reg == DIV_LAST) begin
        div_reg  <= '0;
        half_reg <= half_inc;
        if (half_inc == 5'd18) begin
          busy_reg <= 1'b0;
          half_reg <= '0;
        end else if (half_inc == 5'd17) begin
          cs_reg <= 1'b1;
        end else if (half_inc[0]) begin
          sclk_reg <= 1'b0;
          // bit7 is already on mosi from acceptance; later falls shift.
          if (half_inc != 5'd1) begin
            mosi_reg  <= shift_reg[6];
            shift_reg <= {shift_reg[5:0], 1'b0};
          end
        end else begin
          sclk_reg <= 1'b1;
        end
      end else begin
        div_reg <= div_reg + DIV_W'(1);
      end
    end
  end

  assign oled.cs      = cs_reg;
  assign oled.mosi    = mosi_reg;
  assign oled.dc_c    = dc_reg;
  assign oled.res     = res_reg;
  assign oled.vss_en  = vss_reg;
  assign oled.pmod_en = pmod_reg;
  assign sclk         = sclk_reg;
  assign init_ready   = init_reg;
  assign display_on   = disp_reg;

endmodule

// File: tb/tb_oled_ctrl.sv
// tb_oled_ctrl: directed bench for oled_ctrl with a timestamp-based reference
// model and per-cycle output comparison, plus literal timing checks.
module tb_oled_ctrl;
  localparam int D    = 2;
  localparam int TVDD = 10;
  localparam int TRES = 4;
  localparam int TVCC = 20;
  localparam int TOFF = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk;
  logic       power_on = 1'b0;
  logic       vcc_on = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] tx_data = 8'h00;
  logic       tx_dc = 1'b0;
  logic       init_ready;
  logic       display_on;

  oled_if bus ();

  oled_ctrl #(
    .CLK_DIV(D), .T_VDD(TVDD), .T_RES(TRES), .T_VCC(TVCC), .T_OFF(TOFF)
  ) dut (
    .clk(clk), .rst(rst), .oled(bus), .sclk(sclk),
    .power_on(power_on), .vcc_on(vcc_on),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_dc(tx_dc),
    .init_ready(init_ready), .display_on(display_on)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int t     = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s t=%0d got=%0d want=%0d", name, t, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Modes are milestones of the power sequence; timing inside a mode and
  // inside a frame is pure arithmetic on the entry/start timestamps.
  typedef enum int {M_OFF, M_SEQ, M_INIT, M_VCC, M_RUN, M_DOWN} mode_t;
  mode_t      m_mode = M_OFF;
  mode_t      m_nm;
  int         m_t0 = 0;
  logic       f_valid = 1'b0;
  int         f_start = 0;
  logic [7:0] f_data = 8'h00;
  logic       f_dc = 1'b0;
  logic       m_busy, m_rdy;
  logic       e_cs, e_sclk, e_mosi, e_dc, e_res, e_pmod, e_vss, e_init, e_disp;
  int         el, kk, idx;

  always_comb begin
    m_busy = f_valid && (t < f_start + 18 * D);
    el     = t + 1 - m_t0;
    m_nm   = m_mode;
    case (m_mode)
      M_OFF:  if (power_on) m_nm = M_SEQ;
      M_SEQ:  if (!power_on) m_nm = M_OFF; else if (el == TVDD + 2 * TRES) m_nm = M_INIT;
      M_INIT: if (!m_busy && !power_on) m_nm = M_OFF; else if (!m_busy && vcc_on) m_nm = M_VCC;
      M_VCC:  if (el == TVCC) m_nm = M_RUN;
      M_RUN:  if (!m_busy && (!vcc_on || !power_on)) m_nm = M_DOWN;
      M_DOWN: if (el == TOFF) m_nm = power_on ? M_INIT : M_OFF;
      default: m_nm = m_mode;
    endcase
    m_rdy  = (m_mode == M_INIT || m_mode == M_VCC || m_mode == M_RUN) && !m_busy && (m_nm == m_mode);
    e_pmod = (m_mode != M_OFF);
    e_res  = !(m_mode == M_SEQ && (t - m_t0) >= TVDD && (t - m_t0) < TVDD + TRES);
    e_vss  = (m_mode == M_VCC || m_mode == M_RUN);
    e_init = (m_mode == M_INIT || m_mode == M_VCC || m_mode == M_RUN);
    e_disp = (m_mode == M_RUN);
    kk  = 0;
    idx = 0;
    if (f_valid && t < f_start + 17 * D) begin
      kk     = (t - f_start) / D;
      idx    = (kk == 0) ? 7 : 8 - (kk + 1) / 2;
      e_cs   = 1'b0;
      e_sclk = (kk % 2 == 1) ? 1'b0 : 1'b1;
      e_mosi = f_data[idx[2:0]];
      e_dc   = f_dc;
    end else begin
      e_cs   = 1'b1;
      e_sclk = 1'b1;
      e_mosi = f_valid ? f_data[0] : 1'b0;
      e_dc   = f_valid ? f_dc : 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_mode  <= M_OFF;
      m_t0    <= t + 1;
      f_valid <= 1'b0;
    end else begin
      if (tx_valid && m_rdy) begin
        f_valid <= 1'b1;
        f_start <= t + 1;
        f_data  <= tx_data;
        f_dc    <= tx_dc;
      end
      if (m_nm != m_mode) begin
        m_mode <= m_nm;
        m_t0   <= t + 1;
      end
    end
    t <= t + 1;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("cs", bus.cs, e_cs);
      check("sclk", sclk, e_sclk);
      check("mosi", bus.mosi, e_mosi);
      check("dc_c", bus.dc_c, e_dc);
      check("res", bus.res, e_res);
      check("pmod_en", bus.pmod_en, e_pmod);
      check("vss_en", bus.vss_en, e_vss);
      check("init_ready", init_ready, e_init);
      check("display_on", display_on, e_disp);
      check("tx_ready", tx_ready, m_rdy);
    end
  end

  // ---------------- event monitor ----------------
  logic p_cs = 1'b1, p_sclk = 1'b1, p_pmod = 1'b0, p_res = 1'b1;
  logic p_init = 1'b0, p_vss = 1'b0, p_disp = 1'b0;
  int pmod_rise_t = 0, pmod_fall_t = 0, res_fall_t = 0, res_rise_t = 0;
  int init_rise_t = 0, vss_rise_t = 0, vss_fall_t = 0, disp_rise_t = 0;
  int fr_cnt = 0, fr_fall_t = 0, fr_rise_t = 0, gap_now = 0, sclk_edges = 0;
  int cur_rises = 0;
  logic [7:0] cur_byte = 8'h00;
  logic cur_dc = 1'b0, cur_dc_bad = 1'b0;
  logic [7:0] fr_byte [16];
  int   fr_len [16];
  int   fr_rises [16];
  int   fr_gap [16];
  logic fr_dc [16];
  logic fr_dcbad [16];

  always @(negedge clk) begin
    p_cs <= bus.cs; p_sclk <= sclk; p_pmod <= bus.pmod_en; p_res <= bus.res;
    p_init <= init_ready; p_vss <= bus.vss_en; p_disp <= display_on;
    if (bus.pmod_en && !p_pmod) pmod_rise_t <= t;
    if (!bus.pmod_en && p_pmod) pmod_fall_t <= t;
    if (!bus.res && p_res) res_fall_t <= t;
    if (bus.res && !p_res) res_rise_t <= t;
    if (init_ready && !p_init) init_rise_t <= t;
    if (bus.vss_en && !p_vss) vss_rise_t <= t;
    if (!bus.vss_en && p_vss) vss_fall_t <= t;
    if (display_on && !p_disp) disp_rise_t <= t;
    if (sclk != p_sclk) sclk_edges <= sclk_edges + 1;
    if (!bus.cs && p_cs) begin
      fr_fall_t  <= t;
      gap_now    <= t - fr_rise_t;
      cur_rises  <= 0;
      cur_byte   <= 8'h00;
      cur_dc     <= bus.dc_c;
      cur_dc_bad <= 1'b0;
    end else if (!bus.cs) begin
      if (sclk && !p_sclk) begin
        cur_rises <= cur_rises + 1;
        cur_byte  <= {cur_byte[6:0], bus.mosi};
      end
      if (bus.dc_c != cur_dc) cur_dc_bad <= 1'b1;
    end
    if (bus.cs && !p_cs && fr_cnt < 16) begin
      fr_byte[fr_cnt]  <= cur_byte;
      fr_len[fr_cnt]   <= t - fr_fall_t;
      fr_rises[fr_cnt] <= cur_rises;
      fr_gap[fr_cnt]   <= gap_now;
      fr_dc[fr_cnt]    <= cur_dc;
      fr_dcbad[fr_cnt] <= cur_dc_bad;
      fr_rise_t        <= t;
      fr_cnt           <= fr_cnt + 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_accept();
    int n = 0;
    while (!tx_ready && n < 300) begin
      tick();
      n++;
    end
    check("accept_seen", tx_ready, 1);
    tick();
  endtask

  task automatic send(input logic [7:0] data, input logic dc);
    tx_valid = 1'b1;
    tx_data  = data;
    tx_dc    = dc;
    wait_accept();
    tx_valid = 1'b0;
  endtask

  task automatic wait_ready(output int at);
    int n = 0;
    while (!tx_ready && n < 300) begin
      tick();
      n++;
    end
    at = t;
    check("ready_seen", tx_ready, 1);
  endtask

  task automatic wait_init();
    int n = 0;
    while (!init_ready && n < 300) begin
      tick();
      n++;
    end
    check("init_seen", init_ready, 1);
    tick();
  endtask

  initial begin
    int p0, d0, at, base, n, hits, edges0;

    repeat (3) tick();
    check("rst_cs", bus.cs, 1);
    check("rst_sclk", sclk, 1);
    check("rst_res", bus.res, 1);
    check("rst_pmod", bus.pmod_en, 0);
    check("rst_mosi", bus.mosi, 0);
    check("rst_ready", tx_ready, 0);
    check("rst_init", init_ready, 0);
    rst = 1'b0;
    tick();
    tick();

    // Power-up sequence.
    power_on = 1'b1;
    p0 = t;
    wait_init();
    check("pu_pmod_rise", pmod_rise_t - p0, 1);
    check("pu_res_fall", res_fall_t - p0, 11);
    check("pu_res_low", res_rise_t - res_fall_t, 4);
    check("pu_init_rise", init_rise_t - p0, 19);

    // Single command byte 0xA5.
    base = fr_cnt;
    send(8'hA5, 1'b0);
    wait_ready(at);
    tick();
    check("a5_byte", fr_byte[base], 32'hA5);
    check("a5_cs_low", fr_len[base], 34);
    check("a5_rises", fr_rises[base], 8);
    check("a5_dc", fr_dc[base], 0);
    check("a5_dc_stable", fr_dcbad[base], 0);
    check("a5_ready_ret", at - fr_fall_t, 36);

    // Back-to-back data bytes; one byte per 18*D+1 cycles leaves cs high
    // for D+1 cycles between frames.
    base = fr_cnt;
    tx_valid = 1'b1; tx_data = 8'h00; tx_dc = 1'b1;
    wait_accept();
    tx_data = 8'hFF;
    wait_accept();
    tx_valid = 1'b0;
    wait_ready(at);
    tick();
    check("b2b_byte0", fr_byte[base], 32'h00);
    check("b2b_byte1", fr_byte[base + 1], 32'hFF);
    check("b2b_gap", fr_gap[base + 1], 3);
    check("b2b_dc0", fr_dc[base], 1);
    check("b2b_dc1", fr_dc[base + 1], 1);
    check("b2b_rises1", fr_rises[base + 1], 8);

    // vcc_on raised while a frame is in flight.
    base = fr_cnt;
    send(8'h3C, 1'b0);
    vcc_on = 1'b1;
    n = 0;
    while (!display_on && n < 300) begin
      tick();
      n++;
    end
    check("vcc_disp_seen", display_on, 1);
    tick();
    check("vcc_byte", fr_byte[base], 32'h3C);
    check("vcc_rises", fr_rises[base], 8);
    check("vcc_vss_rise", vss_rise_t - fr_fall_t, 37);
    check("vcc_disp_rise", disp_rise_t - fr_fall_t, 57);

    // Transfer in RUN.
    base = fr_cnt;
    send(8'h81, 1'b1);
    wait_ready(at);
    tick();
    check("run_byte", fr_byte[base], 32'h81);
    check("run_dc", fr_dc[base], 1);

    // Power-down from RUN with a byte offered during OFF_WAIT.
    base = fr_cnt;
    power_on = 1'b0;
    d0 = t;
    tick();
    tick();
    tx_valid = 1'b1; tx_data = 8'h77; tx_dc = 1'b1;
    hits = 0;
    n = 0;
    while (bus.pmod_en && n < 100) begin
      if (tx_ready) hits++;
      tick();
      n++;
    end
    tick();
    check("pd_vss_fall", vss_fall_t - d0, 1);
    check("pd_pmod_fall", pmod_fall_t - d0, 31);
    check("pd_ready_hits", hits, 0);
    check("pd_no_frame", fr_cnt - base, 0);
    check("pd_init_low", init_ready, 0);
    tx_valid = 1'b0;
    vcc_on = 1'b0;
    tick();

    // Power up again, then asynchronous reset after the 3rd rising edge.
    power_on = 1'b1;
    wait_init();
    send(8'hC3, 1'b0);
    n = 0;
    while (cur_rises < 3 && n < 100) begin
      tick();
      n++;
    end
    check("mid_rises_seen", (cur_rises >= 3) ? 1 : 0, 1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("arst_cs", bus.cs, 1);
    check("arst_sclk", sclk, 1);
    check("arst_pmod", bus.pmod_en, 0);
    check("arst_res", bus.res, 1);
    check("arst_ready", tx_ready, 0);
    power_on = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    edges0 = sclk_edges;
    repeat (40) tick();
    check("arst_no_sclk", sclk_edges - edges0, 0);
    check("arst_pmod_off", bus.pmod_en, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
